// File: rtl/operand_collector_pkg.sv
// Shared types for the operand collector: source selects and FSM states.
package operand_collector_pkg;

  typedef enum logic [1:0] {
    SRC_RF  = 2'b00,
    SRC_MEM = 2'b01,
    SRC_IMM = 2'b10
  } src_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_MEM_WAIT = 2'b01,
    ST_HOLD     = 2'b10
  } state_e;

endpackage

// File: rtl/operand_collector_mem_wait_timer.sv
// Down-counter bounding the memory-acknowledge wait; expired is high in the
// last allowed wait cycle so an acknowledge in that cycle can still win.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic clear,
  output logic expired
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  logic          active_q, active_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    active_d = active_q;
    cnt_d    = cnt_q;
    if (start) begin
      active_d = 1'b1;
      cnt_d    = CW'(MEM_TIMEOUT - 1);
    end else if (clear) begin
      active_d = 1'b0;
    end else if (active_q && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      active_q <= active_d;
      cnt_q    <= cnt_d;
    end
  end

  assign expired = active_q && (cnt_q == '0);

endmodule

// File: rtl/operand_collector.sv
// Collects one operand from register file, immediate or memory and holds it
// until consumed. Define OPERAND_COLLECTOR_TIMEOUT_EN to bound the memory wait.
module operand_collector
  import operand_collector_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int SELECT_BITS = 2,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [SELECT_BITS-1:0] req_select,
  input  logic [DATA_WIDTH-1:0]  data_rf,
  input  logic [DATA_WIDTH-1:0]  data_imm,
  output logic                   mem_rd_req,
  input  logic                   mem_rd_ack,
  input  logic [DATA_WIDTH-1:0]  mem_rd_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic [SELECT_BITS-1:0] out_source,
  output logic                   out_err
);

  state_e                 state_q;
  logic                   mem_rd_req_q;
  logic                   out_valid_q;
  logic [DATA_WIDTH-1:0]  out_data_q;
  logic [SELECT_BITS-1:0] out_source_q;

  logic accept;
  logic sel_mem;
  logic sel_imm;
  logic timeout_expired;

  assign accept  = req_valid && (state_q == ST_IDLE);
  assign sel_mem = (req_select == SELECT_BITS'(SRC_MEM));
  assign sel_imm = (req_select == SELECT_BITS'(SRC_IMM));

`ifdef OPERAND_COLLECTOR_TIMEOUT_EN
  logic out_err_q;
  logic timer_clear;

  assign timer_clear = (state_q == ST_MEM_WAIT) && (mem_rd_ack || timeout_expired);

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_mem_wait_timer (
    .clk    (clk),
    .rst    (rst),
    .start  (accept && sel_mem),
    .clear  (timer_clear),
    .expired(timeout_expired)
  );

  // Error only when the wait expires with no acknowledge in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_err_q <= 1'b0;
    end else if (accept) begin
      out_err_q <= 1'b0;
    end else if ((state_q == ST_MEM_WAIT) && !mem_rd_ack && timeout_expired) begin
      out_err_q <= 1'b1;
    end
  end

  assign out_err = out_err_q;
`else
  assign timeout_expired = 1'b0;
  assign out_err         = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      mem_rd_req_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_source_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            out_source_q <= req_select;
            if (sel_mem) begin
              mem_rd_req_q <= 1'b1;
              state_q      <= ST_MEM_WAIT;
            end else begin
              out_data_q  <= sel_imm ? data_imm : data_rf;
              out_valid_q <= 1'b1;
              state_q     <= ST_HOLD;
            end
          end
        end
        ST_MEM_WAIT: begin
          if (mem_rd_ack) begin
            out_data_q   <= mem_rd_data;
            mem_rd_req_q <= 1'b0;
            out_valid_q  <= 1'b1;
            state_q      <= ST_HOLD;
          end else if (timeout_expired) begin
            out_data_q   <= '0;
            mem_rd_req_q <= 1'b0;
            out_valid_q  <= 1'b1;
            state_q      <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q      <= ST_IDLE;
          mem_rd_req_q <= 1'b0;
          out_valid_q  <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign mem_rd_req = mem_rd_req_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_source = out_source_q;

endmodule

// File: tb/tb_operand_collector.sv
// Scoreboard bench for operand_collector; timeout scenarios run when
// OPERAND_COLLECTOR_TIMEOUT_EN is defined.
module tb_operand_collector;

  localparam int DW = 8;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [SW-1:0] req_select;
  logic [DW-1:0] data_rf;
  logic [DW-1:0] data_imm;
  logic          mem_rd_req;
  logic          mem_rd_ack;
  logic [DW-1:0] mem_rd_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [SW-1:0] out_source;
  logic          out_err;

  typedef struct {
    logic [DW-1:0] data;
    logic [SW-1:0] src;
    logic          err;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  operand_collector #(
    .DATA_WIDTH (DW),
    .SELECT_BITS(SW),
    .MEM_TIMEOUT(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_select (req_select),
    .data_rf    (data_rf),
    .data_imm   (data_imm),
    .mem_rd_req (mem_rd_req),
    .mem_rd_ack (mem_rd_ack),
    .mem_rd_data(mem_rd_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_source (out_source),
    .out_err    (out_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one accepted request and push what the collector must deliver.
  task automatic issue(input logic [SW-1:0] sel, input logic [DW-1:0] rf,
                       input logic [DW-1:0] imm, input logic push_exp,
                       input logic [DW-1:0] mem_val, input logic mem_err);
    exp_t e;
    req_valid  = 1'b1;
    req_select = sel;
    data_rf    = rf;
    data_imm   = imm;
    if (push_exp) begin
      e.src = sel;
      e.err = 1'b0;
      if (sel == 2'b01) begin
        e.data = mem_err ? '0 : mem_val;
        e.err  = mem_err;
      end else if (sel == 2'b10) begin
        e.data = imm;
      end else begin
        e.data = rf;
      end
      sb_q.push_back(e);
    end
    chk("accept_ready", req_ready, 1);
    tick();
    req_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_out", 1, 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("sb_data", out_data, e.data);
        chk("sb_source", out_source, e.src);
        chk("sb_err", out_err, e.err);
      end
    end
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_select = '0; data_rf = '0; data_imm = '0;
    mem_rd_ack = 1'b0; mem_rd_data = '0; out_ready = 1'b0;
    tick();
    tick();
    chk("rst_req_ready", req_ready, 1);
    chk("rst_mem_rd_req", mem_rd_req, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_source", out_source, 0);
    chk("rst_out_err", out_err, 0);
    rst = 1'b0;
    tick();

    // rf select, one-cycle latency
    out_ready = 1'b1;
    chk("rf_pre_valid", out_valid, 0);
    issue(2'b00, 8'h3C, 8'h11, 1'b1, 8'h00, 1'b0);
    chk("rf_valid_lat1", out_valid, 1);
    chk("rf_req_ready_low", req_ready, 0);
    tick();
    chk("rf_back_idle", req_ready, 1);
    chk("rf_valid_drop", out_valid, 0);

    // stray acknowledge in IDLE is ignored
    mem_rd_ack = 1'b1; mem_rd_data = 8'hEE;
    tick();
    mem_rd_ack = 1'b0;
    chk("idle_ack_ignored_valid", out_valid, 0);
    chk("idle_ack_ignored_ready", req_ready, 1);

    // memory read, ack sampled in the third request cycle
    issue(2'b01, 8'h00, 8'h00, 1'b1, 8'hA5, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("mem_req_high", mem_rd_req, 1);
      chk("mem_wait_no_valid", out_valid, 0);
      if (i == 2) begin
        mem_rd_ack = 1'b1; mem_rd_data = 8'hA5;
      end
      tick();
    end
    mem_rd_ack = 1'b0; mem_rd_data = 8'h00;
    chk("mem_req_dropped", mem_rd_req, 0);
    chk("mem_valid", out_valid, 1);
    tick();
    chk("mem_back_idle", req_ready, 1);

    // imm select with consumer stalled; requests in HOLD have no effect
    out_ready = 1'b0;
    issue(2'b10, 8'h22, 8'h7F, 1'b1, 8'h00, 1'b0);
    req_valid = 1'b1; req_select = 2'b00; data_rf = 8'h99; data_imm = 8'h55;
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_data", out_data, 8'h7F);
      chk("hold_source", out_source, 2'b10);
      chk("hold_req_ready_low", req_ready, 0);
      tick();
    end
    req_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("hold_release_idle", req_ready, 1);
    chk("hold_release_valid", out_valid, 0);

    // select 11 behaves as rf
    issue(2'b11, 8'h5A, 8'hC3, 1'b1, 8'h00, 1'b0);
    chk("sel11_valid", out_valid, 1);
    tick();

    // reset two cycles into MEM_WAIT, ack in the reset cycle and after
    issue(2'b01, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    tick();
    tick();
    chk("rst_mid_req_high", mem_rd_req, 1);
    rst = 1'b1; mem_rd_ack = 1'b1; mem_rd_data = 8'hEE;
    tick();
    rst = 1'b0;
    chk("rst_mid_req_low", mem_rd_req, 0);
    chk("rst_mid_no_valid", out_valid, 0);
    chk("rst_mid_idle", req_ready, 1);
    chk("rst_mid_data", out_data, 0);
    tick();
    mem_rd_ack = 1'b0;
    chk("late_ack_no_valid", out_valid, 0);
    chk("late_ack_idle", req_ready, 1);
    chk("late_ack_req_low", mem_rd_req, 0);

`ifdef OPERAND_COLLECTOR_TIMEOUT_EN
    // no acknowledge: error after four wait cycles
    issue(2'b01, 8'h00, 8'h00, 1'b1, 8'h00, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk("to_req_high", mem_rd_req, 1);
      chk("to_no_valid", out_valid, 0);
      tick();
    end
    chk("to_valid", out_valid, 1);
    chk("to_req_low", mem_rd_req, 0);
    chk("to_err", out_err, 1);
    chk("to_data", out_data, 0);
    tick();
    // acknowledge in the expiry cycle wins
    issue(2'b01, 8'h00, 8'h00, 1'b1, 8'h6B, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("to_ack_req_high", mem_rd_req, 1);
      if (i == 3) begin
        mem_rd_ack = 1'b1; mem_rd_data = 8'h6B;
      end
      tick();
    end
    mem_rd_ack = 1'b0;
    chk("to_ack_valid", out_valid, 1);
    chk("to_ack_err", out_err, 0);
    chk("to_ack_data", out_data, 8'h6B);
    tick();
`else
    // without the timeout the wait is unbounded
    issue(2'b01, 8'h00, 8'h00, 1'b1, 8'h3E, 1'b0);
    for (int i = 0; i < 20; i++) begin
      chk("nto_req_high", mem_rd_req, 1);
      chk("nto_no_valid", out_valid, 0);
      chk("nto_err", out_err, 0);
      if (i == 19) begin
        mem_rd_ack = 1'b1; mem_rd_data = 8'h3E;
      end
      tick();
    end
    mem_rd_ack = 1'b0;
    chk("nto_valid", out_valid, 1);
    tick();
`endif

    tick();
    chk("sb_drain", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/operand_collector.md
OPERAND_COLLECTOR -- requirements
Module: operand_collector

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of all data paths.
REQ-002 SHALL have parameter SELECT_BITS, default 2, width of source select.
REQ-003 SHALL have parameter MEM_TIMEOUT, default 16, maximum cycles to wait for a memory acknowledge (used only under REQ-027).
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port req_valid, input, 1, collect request offered.
REQ-007 SHALL have port req_ready, output, 1, request accepted when req_valid and req_ready are both high.
REQ-008 SHALL have port req_select, input, SELECT_BITS, source: 00 rf, 01 mem, 10 imm, 11 rf.
REQ-009 SHALL have ports data_rf and data_imm, input, DATA_WIDTH each, register-file and immediate data, valid in the accept cycle.
REQ-010 SHALL have ports mem_rd_req (output, 1), mem_rd_ack (input, 1) and mem_rd_data (input, DATA_WIDTH), the memory read handshake.
REQ-011 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_data (output, DATA_WIDTH) and out_source (output, SELECT_BITS), the collected result.
REQ-012 SHALL have port out_err, output, 1, memory timeout flag.

Function
REQ-013 SHALL implement FSM states IDLE, MEM_WAIT and HOLD.
REQ-014 req_ready SHALL be high only in IDLE; there is no back-to-back acceptance.
REQ-015 IDLE, accept with select 00, 10 or 11: SHALL register data_rf or data_imm into out_data, record the select in out_source, and enter HOLD; out_valid is high the next cycle (1-cycle latency).
REQ-016 IDLE, accept with select 01: SHALL enter MEM_WAIT and assert the registered mem_rd_req from the next cycle.
REQ-017 MEM_WAIT: mem_rd_req SHALL stay high until the cycle mem_rd_ack is sampled high; in that cycle mem_rd_data is captured into out_data and the FSM enters HOLD.
REQ-018 mem_rd_req SHALL be low in the cycle after the acknowledge; out_valid is high in that same cycle.
REQ-019 mem_rd_ack sampled outside MEM_WAIT SHALL be ignored.
REQ-020 HOLD: out_valid SHALL be high; out_data, out_source and out_err stay stable until out_ready is sampled high, after which the FSM enters IDLE.
REQ-021 req_valid outside IDLE SHALL have no effect.
REQ-022 out_valid SHALL be low in IDLE and MEM_WAIT.

Reset
REQ-023 rst high SHALL force IDLE on the next edge from any state, including mid-MEM_WAIT; any in-flight memory acknowledge is discarded.
REQ-024 Reset values SHALL be: req_ready 1 after the reset edge (IDLE), mem_rd_req 0, out_valid 0, out_data 0, out_source 0, out_err 0.
REQ-025 rst SHALL take priority over every handshake in the same cycle.

Configuration
REQ-026 Macro OPERAND_COLLECTOR_TIMEOUT_EN SHALL gate the memory timeout feature.
REQ-027 With the macro defined: a counter SHALL count cycles in MEM_WAIT. On reaching MEM_TIMEOUT without an acknowledge, the FSM enters HOLD with out_data 0, out_err 1 and mem_rd_req dropped. An acknowledge in the expiry cycle wins, giving out_err 0 and the memory data.
REQ-028 Without the macro: MEM_WAIT SHALL wait indefinitely, out_err is tied 0, and no counter is synthesised.

Structure
REQ-029 A shared package SHALL hold the source enum (SRC_RF=2'b00, SRC_MEM=2'b01, SRC_IMM=2'b10) and the FSM state enum.
REQ-030 The timeout counter SHALL be sub-module mem_wait_timer (start, clear, expired), instantiated only under OPERAND_COLLECTOR_TIMEOUT_EN.

Verification
REQ-031 Scenario: select 00, data_rf 0x3C, out_ready 1 -> out_valid high one cycle after accept, out_data 0x3C, out_source 00.
REQ-032 Scenario: select 01, mem_rd_ack 3 cycles after mem_rd_req with data 0xA5 -> mem_rd_req high exactly 3 cycles, out_data 0xA5 the next cycle, out_err 0.
REQ-033 Scenario: select 10, data_imm 0x7F, out_ready held low 5 cycles -> out_data 0x7F stable, req_ready low throughout, IDLE one cycle after out_ready rises.
REQ-034 Scenario: rst asserted 2 cycles into MEM_WAIT, then late mem_rd_ack -> mem_rd_req 0 after the reset edge, no out_valid, the acknowledge is ignored.
REQ-035 Scenario (macro on, MEM_TIMEOUT 4): no acknowledge -> HOLD after 4 cycles with out_err 1 and out_data 0x00; repeat with the acknowledge in the 4th cycle -> out_err 0 and the memory data.
